// File: rtl/rsa_pkg.sv
// Shared defaults and state encoding for the RSA operand front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rsa_pkg;

  localparam int BIT_LEN_DEF = 1024;
  localparam int CNT_W_DEF   = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CHECK = 3'd2,
    DBL   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mod_dbl.sv
// Modular doubling: y = 2x mod n, for x < n and n odd.
// Latency: combinational.
// Backpressure: none.
module mod_dbl
  import rsa_pkg::*;
#(
  parameter int bitLen = BIT_LEN_DEF
) (
  input  logic [bitLen-1:0] x,
  input  logic [bitLen-1:0] n,
  output logic [bitLen-1:0] y
);

  logic [bitLen:0] t;
  logic [bitLen:0] nn;

  // Double at bitLen+1 bits; since x < n, 2x < 2n, so one subtract brings it back below n.
  always_comb begin
    t  = {x, 1'b0};
    nn = {1'b0, n};
    y  = (t >= nn) ? bitLen'(t - nn) : bitLen'(t);
  end

endmodule

// File: rtl/mont_preproc.sv
// Montgomery pre-conditioner: M_bar = M*2^k mod n, x_bar = 2^k mod n, k = bitlen(n), e_idx.
// Latency: stop rises bitLen+1+k edges after the start edge (bitLen+1 on operand error).
// Backpressure: level handshake; stop holds in DONE until start is seen low. Optional MONT_PRE_EIDX_EN.
module mont_preproc
  import rsa_pkg::*;
#(
  parameter int bitLen = BIT_LEN_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [bitLen-1:0] M,
  input  logic [bitLen-1:0] e,
  input  logic [bitLen-1:0] n,
  output logic [bitLen-1:0] M_bar,
  output logic [bitLen-1:0] x_bar,
  output logic [CNT_W-1:0]  mp_count,
  output logic [CNT_W-1:0]  e_idx,
  output logic              stop,
  output logic              err
);

  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
  localparam logic [bitLen-1:0] ONE_B = bitLen'(1);

  state_t            state_q, state_d;
  logic [bitLen-1:0] m_q, m_d, n_q, n_d;
  logic [bitLen-1:0] a_q, a_d, b_q, b_d;
  logic [bitLen-1:0] mbar_q, mbar_d, xbar_q, xbar_d;
  logic [CNT_W-1:0]  i_q, i_d, k_q, k_d, cnt_q, cnt_d;
  logic [CNT_W-1:0]  mpc_q, mpc_d, eidx_q, eidx_d;
  logic              stop_q, stop_d, err_q, err_d;
  logic [bitLen-1:0] n_sh, a_dbl, b_dbl;
  logic [CNT_W-1:0]  eidx_fin;

`ifdef MONT_PRE_EIDX_EN
  logic [bitLen-1:0] e_q, e_d, e_sh;
  logic [CNT_W-1:0]  ek_q, ek_d;
  assign e_sh     = e_q >> i_q;
  assign eidx_fin = ek_q;
`else
  // Exponent is not scanned in this build; mon_exp walks the full width.
  logic unused_e;
  assign unused_e = ^e;
  assign eidx_fin = CNT_W'(bitLen);
`endif

  assign n_sh = n_q >> i_q;

  mod_dbl #(.bitLen(bitLen)) u_dbl_a (.x(a_q), .n(n_q), .y(a_dbl));
  mod_dbl #(.bitLen(bitLen)) u_dbl_b (.x(b_q), .n(n_q), .y(b_dbl));

  // Next-state and datapath: scan for bit lengths, validate operands, then k doublings.
  always_comb begin
    state_d = state_q;
    m_d = m_q;  n_d = n_q;  a_d = a_q;  b_d = b_q;
    mbar_d = mbar_q;  xbar_d = xbar_q;
    i_d = i_q;  k_d = k_q;  cnt_d = cnt_q;
    mpc_d = mpc_q;  eidx_d = eidx_q;
    stop_d = stop_q;  err_d = err_q;
`ifdef MONT_PRE_EIDX_EN
    e_d = e_q;  ek_d = ek_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d = M;
          n_d = n;
          stop_d = 1'b0;
          err_d = 1'b0;
          i_d = CNT_W'(bitLen - 1);
          k_d = '0;
`ifdef MONT_PRE_EIDX_EN
          e_d = e;
          ek_d = '0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        // A zero length means "no set bit seen yet", so only the topmost one latches.
        if (n_sh[0] && (k_q == '0)) k_d = i_q + ONE;
`ifdef MONT_PRE_EIDX_EN
        if (e_sh[0] && (ek_q == '0)) ek_d = i_q + ONE;
`endif
        if (i_q == '0) state_d = CHECK;
        else           i_d = i_q - ONE;
      end
      CHECK: begin
        if ((n_q == '0) || !n_q[0] || (m_q >= n_q)) begin
          err_d = 1'b1;
          stop_d = 1'b1;
          mbar_d = '0;
          xbar_d = '0;
          mpc_d = '0;
          eidx_d = '0;
          state_d = DONE;
        end else begin
          a_d = m_q;
          b_d = ONE_B;
          cnt_d = k_q;
          state_d = DBL;
        end
      end
      DBL: begin
        a_d = a_dbl;
        b_d = b_dbl;
        cnt_d = cnt_q - ONE;
        // Last doubling: publish the freshly doubled values directly.
        if (cnt_q == ONE) begin
          mbar_d = a_dbl;
          xbar_d = b_dbl;
          mpc_d = k_q;
          eidx_d = eidx_fin;
          stop_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          stop_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;  n_q <= '0;  a_q <= '0;  b_q <= '0;
      mbar_q <= '0;  xbar_q <= '0;
      i_q <= '0;  k_q <= '0;  cnt_q <= '0;
      mpc_q <= '0;  eidx_q <= '0;
      stop_q <= 1'b0;  err_q <= 1'b0;
`ifdef MONT_PRE_EIDX_EN
      e_q <= '0;  ek_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      m_q <= m_d;  n_q <= n_d;  a_q <= a_d;  b_q <= b_d;
      mbar_q <= mbar_d;  xbar_q <= xbar_d;
      i_q <= i_d;  k_q <= k_d;  cnt_q <= cnt_d;
      mpc_q <= mpc_d;  eidx_q <= eidx_d;
      stop_q <= stop_d;  err_q <= err_d;
`ifdef MONT_PRE_EIDX_EN
      e_q <= e_d;  ek_q <= ek_d;
`endif
    end
  end

  assign M_bar    = mbar_q;
  assign x_bar    = xbar_q;
  assign mp_count = mpc_q;
  assign e_idx    = eidx_q;
  assign stop     = stop_q;
  assign err      = err_q;

endmodule
